// File: rtl/main_mem_model.sv
// Block-wide main-memory model for the cache refill/write-back port, with a request/ready handshake.
// Latency: mem_ready rises LATENCY (+ LFSR extra in random mode) edges after acceptance and lasts one cycle.
// Backpressure: a request is sampled only in IDLE; the requester holds it until mem_ready, then drops it.
module main_mem_model #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WORD_WIDTH  = 32,
    parameter int          BLOCK_WORDS = 4,
    parameter int          LATENCY     = 4,
    parameter int          RANDOM_MODE = 0,
    parameter int          MAX_EXTRA   = 7,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [WORD_WIDTH*BLOCK_WORDS-1:0] mem_writedata,
    output logic [WORD_WIDTH*BLOCK_WORDS-1:0] mem_readdata,
    output logic                              mem_ready,
    output logic                              err_both,
    output logic [15:0]                       rd_count,
    output logic [15:0]                       wr_count
);

    localparam int OFF   = $clog2(BLOCK_WORDS);
    localparam int IDX_W = ADDR_WIDTH - OFF;
    localparam int DEPTH = 1 << IDX_W;
    localparam int BLK_W = WORD_WIDTH * BLOCK_WORDS;
    localparam int WC_W  = $clog2(LATENCY + MAX_EXTRA + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic              op_wr;
    logic [IDX_W-1:0]  blk_idx;
    logic [BLK_W-1:0]  wdata_q;
    logic [WC_W-1:0]   wait_cnt;
    logic [WC_W-1:0]   wait_load;
    logic [7:0]        lfsr;
    logic              accept;
    logic              done;
    logic              unused_addr_bits;

    // Block storage; deliberately not cleared by reset.
    logic [BLK_W-1:0]  mem [DEPTH];

    // Low address bits only select a word inside the block, which is always transferred whole.
    assign unused_addr_bits = ^mem_addr;

    assign accept    = (state == IDLE) && (mem_read || mem_write);
    assign done      = (state == BUSY) && (wait_cnt == '0);
    assign mem_ready = (state == RESP);

    // Wait count for a new request; random mode adds extra cycles from the pre-advance LFSR value.
    always_comb begin
        wait_load = WC_W'(LATENCY - 1);
        if (RANDOM_MODE != 0)
            wait_load = WC_W'(LATENCY - 1) + WC_W'(lfsr & 8'(MAX_EXTRA));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> BUSY on acceptance, BUSY -> RESP when the wait expires, RESP -> IDLE always.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (done)   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait countdown and LFSR; a read+write collision is treated as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr    <= 1'b0;
            blk_idx  <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            lfsr     <= LFSR_SEED;
            err_both <= 1'b0;
        end else if (accept) begin
            op_wr    <= mem_write;
            blk_idx  <= mem_addr[ADDR_WIDTH-1:OFF];
            wdata_q  <= mem_writedata;
            wait_cnt <= wait_load;
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (mem_read && mem_write) err_both <= 1'b1;
        end else if (state == BUSY && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Saturating request statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (accept) begin
            if (mem_write) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
            end else if (rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    // Write commit at completion; reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (done && op_wr) mem[blk_idx] <= wdata_q;
    end

    // Read data is loaded at completion and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                mem_readdata <= '0;
        else if (done && !op_wr) mem_readdata <= mem[blk_idx];
    end

endmodule

// File: tb/tb_main_mem_model.sv
// Directed bench for main_mem_model: fixed-latency instance plus a random-latency instance.
// Inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// All transfers are bounded; an expired bound counts as a failed check.
module tb_main_mem_model;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    // fixed-latency instance
    logic         read = 1'b0, write = 1'b0;
    logic [9:0]   addr = '0;
    logic [127:0] wdata = '0, rdata;
    logic         ready, err;
    logic [15:0]  rdc, wrc;

    // random-latency instance
    logic         r_read = 1'b0, r_write = 1'b0;
    logic [9:0]   r_addr = '0;
    logic [127:0] r_wdata = '0, r_rdata;
    logic         r_ready, r_err;
    logic [15:0]  r_rdc, r_wrc;

    localparam logic [127:0] BLK_A = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    localparam logic [127:0] BLK_B = 128'hDEAD;
    localparam logic [127:0] BLK_C = 128'h1234_5678_9ABC_DEF0_0F0F_F0F0_5555_AAAA;

    main_mem_model #(.LATENCY(4), .RANDOM_MODE(0)) dut (
        .clk(clk), .rst(rst), .mem_read(read), .mem_write(write), .mem_addr(addr),
        .mem_writedata(wdata), .mem_readdata(rdata), .mem_ready(ready),
        .err_both(err), .rd_count(rdc), .wr_count(wrc));

    main_mem_model #(.LATENCY(2), .RANDOM_MODE(1), .MAX_EXTRA(7), .LFSR_SEED(8'hA5)) dut_r (
        .clk(clk), .rst(rst), .mem_read(r_read), .mem_write(r_write), .mem_addr(r_addr),
        .mem_writedata(r_wdata), .mem_readdata(r_rdata), .mem_ready(r_ready),
        .err_both(r_err), .rd_count(r_rdc), .wr_count(r_wrc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer: hold the request until mem_ready, report latency (edges from acceptance)
    // and read data, then confirm the ready pulse lasted a single cycle.
    task automatic xfer(input bit rnd, input bit rd, input bit wr, input logic [9:0] a,
                        input logic [127:0] d, output int lat, output logic [127:0] q);
        int n;
        bit seen;
        if (rnd) begin r_read = rd; r_write = wr; r_addr = a; r_wdata = d; end
        else     begin read = rd;   write = wr;   addr = a;   wdata = d;   end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            seen = rnd ? r_ready : ready;
        end
        read = 1'b0; write = 1'b0; r_read = 1'b0; r_write = 1'b0;
        if (!seen) begin
            chk("xfer_timeout", 0, 1);
            lat = -1;
            q = '0;
        end else begin
            lat = n - 1;
            q = rnd ? r_rdata : rdata;
        end
        @(posedge clk); #1;
        chk("ready_one_cycle", rnd ? r_ready : ready, 0);
    endtask

    initial begin
        int lat, t1, t2, n, pulses;
        logic [127:0] q;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_rdc", rdc, 0);
        chk("rst_wrc", wrc, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fixed latency read of an untouched block
        xfer(0, 1, 0, 10'h010, '0, lat, q);
        chk("rd_latency", lat, 4);
        chk("rd_data_init", q, 0);
        chk("rd_count_1", rdc, 1);

        // Write then read with unaligned address
        xfer(0, 0, 1, 10'h020, BLK_A, lat, q);
        chk("wr_latency", lat, 4);
        chk("wr_count_1", wrc, 1);
        chk("wr_keeps_rdata", rdata, 0);
        xfer(0, 1, 0, 10'h023, '0, lat, q);
        chk("raw_data", q, BLK_A);
        chk("rd_count_2", rdc, 2);

        // Held read: second acceptance two edges after the ready edge
        read = 1'b1; addr = 10'h020;
        n = 0;
        while (!ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("held_first_seen", ready, 1);
        t1 = cyc;
        @(posedge clk);
        @(posedge clk); #1;
        read = 1'b0;
        n = 0;
        while (!ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("held_second_seen", ready, 1);
        t2 = cyc;
        chk("held_gap", t2 - t1, 6);
        chk("held_data", rdata, BLK_A);
        pulses = 0;
        repeat (10) begin @(posedge clk); #1; if (ready) pulses++; end
        chk("held_no_third", pulses, 0);
        chk("held_rd_count", rdc, 4);

        // Random latency: seed A5 -> extra 5, then 4A -> extra 2
        xfer(1, 1, 0, 10'h000, '0, lat, q);
        chk("rand_lat_1", lat, 7);
        xfer(1, 1, 0, 10'h004, '0, lat, q);
        chk("rand_lat_2", lat, 4);
        chk("rand_rd_count", r_rdc, 2);
        chk("rand_wr_count", r_wrc, 0);
        chk("rand_err", r_err, 0);

        // Simultaneous read and write behaves as a write
        xfer(0, 1, 1, 10'h030, BLK_B, lat, q);
        chk("both_err", err, 1);
        chk("both_wr_count", wrc, 2);
        chk("both_rd_count", rdc, 4);
        xfer(0, 1, 0, 10'h031, '0, lat, q);
        chk("both_committed", q, BLK_B);
        chk("both_err_sticky", err, 1);
        chk("both_rd_count_after", rdc, 5);

        // Reset two cycles into a write aborts it
        write = 1'b1; addr = 10'h040; wdata = BLK_C;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        write = 1'b0;
        chk("abort_ready_in_rst", ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin @(posedge clk); #1; if (ready) pulses++; end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_rdc", rdc, 0);
        chk("abort_wrc", wrc, 0);
        chk("abort_err", err, 0);
        xfer(0, 1, 0, 10'h040, '0, lat, q);
        chk("abort_lat", lat, 4);
        chk("abort_old_data", q, 0);
        chk("abort_rd_count", rdc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
